// File: rtl/ffs_iter_m_if.sv
// ffs_iter_m_if: handshake bundle for the set-bit iterator.
//   in_valid/in_ready/in             : vector load channel (producer -> iterator)
//   out_valid/out_ready/out/out_last : index stream (iterator -> consumer)
// Modports: master = producer/consumer side, slave = the iterator itself.
interface ffs_iter_m_if #(
  parameter int INPUT_WIDTH = 8
);
  localparam int IW = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH;
  localparam int OW = (IW < 2) ? 1 : $clog2(IW);

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;
  logic          out_last;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last
  );
endinterface

// File: rtl/ffs_iter_m.sv
// ffs_m: priority encoder returning the index of the first set bit.
//   i_vec : input vector
//   o_idx : index of the highest-priority set bit (0 when i_vec == 0)
//   SIDE  : 0 = msb has priority, 1 = lsb has priority
//
// ffs_iter_m: loads one vector and emits the index of every set bit, one per
// accepted beat, in SIDE order, clearing each bit as it is emitted.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ffs_iter_m_if slave (in_valid/in_ready/in, out_valid/out_ready/out/out_last)
module ffs_m #(
  parameter int INPUT_WIDTH = 8,
  parameter bit SIDE        = 1'b0,
  localparam int IW = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH,
  localparam int OW = (IW < 2) ? 1 : $clog2(IW)
) (
  input  logic [IW-1:0] i_vec,
  output logic [OW-1:0] o_idx
);
  // Scan away from the priority end so the last hit seen is the winner.
  always_comb begin
    o_idx = '0;
    if (SIDE == 1'b0) begin
      for (int j = 0; j < IW; j++) begin
        if (i_vec[j]) o_idx = OW'(j);
      end
    end else begin
      for (int j = IW - 1; j >= 0; j--) begin
        if (i_vec[j]) o_idx = OW'(j);
      end
    end
  end
endmodule

module ffs_iter_m #(
  parameter int INPUT_WIDTH = 8,
  parameter bit SIDE        = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  ffs_iter_m_if.slave  bus
);
  localparam int IW = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH;
  localparam int OW = (IW < 2) ? 1 : $clog2(IW);

  // Pending bits; BUSY is simply r_pend != 0.
  logic [IW-1:0] r_pend;
  logic [OW-1:0] w_idx;
  logic          w_busy;
  logic          w_last;
  logic          w_beat;
  logic          w_in_ready;
  logic          w_load;

  ffs_m #(
    .INPUT_WIDTH (IW),
    .SIDE        (SIDE)
  ) u_ffs (
    .i_vec (r_pend),
    .o_idx (w_idx)
  );

  assign w_busy     = |r_pend;
  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign w_last     = w_busy && ((r_pend & (r_pend - IW'(1))) == '0);
  assign w_beat     = w_busy && bus.out_ready;
  assign w_in_ready = !w_busy || (w_beat && w_last);
  assign w_load     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (w_load) begin
      // Load takes precedence over the final clear on the same edge.
      r_pend <= bus.in;
    end else if (w_beat) begin
      r_pend <= r_pend & ~(IW'(1) << w_idx);
    end
  end

  // All outputs derive from r_pend only, so there is no path from in to out.
  assign bus.out_valid = w_busy;
  assign bus.out       = w_busy ? w_idx : '0;
  assign bus.out_last  = w_last;
  assign bus.in_ready  = w_in_ready;
endmodule

// File: tb/tb_ffs_iter_m.sv
module tb_ffs_iter_m;
  localparam int N = 4;

  // Instance configurations: (width, side)
  function automatic int wid(input int g);
    case (g)
      0: return 8;
      1: return 8;
      2: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic bit sd(input int g);
    case (g)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]   drv_in [N];
  logic [N-1:0] drv_valid;
  logic [N-1:0] drv_ready;
  logic [N-1:0] mon_valid;
  logic [N-1:0] mon_in_ready;
  logic [N-1:0] mon_last;
  logic [3:0]   mon_out [N];
  logic         done;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = wid(g);
    localparam bit S = sd(g);

    ffs_iter_m_if #(.INPUT_WIDTH(W)) bus ();

    ffs_iter_m #(
      .INPUT_WIDTH (W),
      .SIDE        (S)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid    = drv_valid[g];
    assign bus.in          = drv_in[g][W-1:0];
    assign bus.out_ready   = drv_ready[g];
    assign mon_valid[g]    = bus.out_valid;
    assign mon_in_ready[g] = bus.in_ready;
    assign mon_last[g]     = bus.out_last;
    assign mon_out[g]      = 4'(bus.out);
  end

  // Scoreboard: per instance, the indices still owed for the current vector, in order.
  int n_chk  = 0;
  int n_pass = 0;
  int exp_q [N][$];

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, i, act, exp, $time);
  endtask

  // Monitor: compare at negedge (+1), then advance the model across the next posedge.
  always begin
    int sz;
    bit rdy;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        chk("rst_out_valid", i, int'(mon_valid[i]), 0);
        chk("rst_in_ready", i, int'(mon_in_ready[i]), 1);
        chk("rst_out", i, int'(mon_out[i]), 0);
        chk("rst_out_last", i, int'(mon_last[i]), 0);
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        sz  = exp_q[i].size();
        rdy = (sz == 0) || (sz == 1 && drv_ready[i]);
        chk("out_valid", i, int'(mon_valid[i]), int'(sz != 0));
        chk("in_ready", i, int'(mon_in_ready[i]), int'(rdy));
        if (sz != 0) begin
          chk("out", i, int'(mon_out[i]), exp_q[i][0]);
          chk("out_last", i, int'(mon_last[i]), int'(sz == 1));
        end else begin
          chk("idle_out", i, int'(mon_out[i]), 0);
          chk("idle_out_last", i, int'(mon_last[i]), 0);
        end
        if (sz != 0 && drv_ready[i]) void'(exp_q[i].pop_front());
        if (drv_valid[i] && rdy) begin
          exp_q[i].delete();
          for (int b = 0; b < wid(i); b++) begin
            int j;
            j = sd(i) ? b : wid(i) - 1 - b;
            if (drv_in[i][j]) exp_q[i].push_back(j);
          end
        end
      end
    end
    if (done) begin
      for (int i = 0; i < N; i++) chk("drained", i, exp_q[i].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    done      = 1'b0;
    rst_n     = 1'b0;
    drv_valid = '0;
    drv_ready = '0;
    for (int i = 0; i < N; i++) drv_in[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // A4 on both 8-bit instances: 7,5,2 and 2,5,7
    drv_ready    = '1;
    drv_valid[0] = 1'b1; drv_in[0] = 8'hA4;
    drv_valid[1] = 1'b1; drv_in[1] = 8'hA4;
    cyc();
    drv_valid = '0;
    repeat (4) cyc();

    // Backpressure on 0x18
    drv_ready[0] = 1'b0;
    drv_valid[0] = 1'b1; drv_in[0] = 8'h18;
    cyc();
    drv_valid[0] = 1'b0;
    repeat (4) cyc();
    drv_ready[0] = 1'b1;
    repeat (3) cyc();

    // Zero vector, then 0x01 with 0x80 offered on its final beat
    drv_valid[0] = 1'b1; drv_in[0] = 8'h00;
    cyc();
    drv_valid[0] = 1'b0;
    repeat (2) cyc();
    drv_valid[0] = 1'b1; drv_in[0] = 8'h01;
    cyc();
    drv_in[0] = 8'h80;
    cyc();
    drv_valid[0] = 1'b0;
    repeat (3) cyc();

    // Reset mid-iteration after two beats of 0xFF
    drv_valid[0] = 1'b1; drv_in[0] = 8'hFF;
    cyc();
    drv_valid[0] = 1'b0;
    repeat (2) cyc();
    drv_ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    drv_ready[0] = 1'b1;
    repeat (5) cyc();

    // Random traffic on all instances
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        drv_valid[i] = 1'($urandom_range(0, 1));
        drv_in[i]    = 8'($urandom);
        if ($urandom_range(0, 15) == 0) drv_in[i] = 8'h00;
        drv_ready[i] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    // Drain
    drv_valid = '0;
    drv_ready = '1;
    repeat (20) cyc();
    done = 1'b1;
    repeat (10) cyc();
    $display("FAIL timeout: monitor did not finish (got running, expected finished)");
    $fatal(1);
  end
endmodule

// File: doc/ffs_iter_m.md
# ffs_iter_m

Sequential set-bit iterator built around a single `ffs_m` instance. It accepts one bit vector through a valid/ready handshake and holds it in a pending register. It then emits the index of every set bit, one per accepted output beat, in priority order. Each emitted bit is cleared after its beat. The block sits directly downstream of request/mask producers and turns a vector of flags into a stream of indices, for example to service interrupt or grant vectors one at a time.

## Interface
- `INPUT_WIDTH`, 8: vector width. Values < 1 are treated as 1.
- `SIDE`, 1'b0: scan order. 0 emits from msb to lsb; 1 emits from lsb to msb. Passed unchanged to the internal `ffs_m`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in` holds a vector to load.
- `in_ready` output 1: block can accept a vector this cycle.
- `in` input `INPUT_WIDTH`: vector to iterate.
- `out_valid` output 1: `out` holds a valid index.
- `out_ready` input 1: consumer takes the beat this cycle.
- `out` output $clog2(max(INPUT_WIDTH,2)): index of the current highest-priority set bit.
- `out_last` output 1: current beat is the last set bit of the vector.

## Operation
- The state is the pending register `pend[INPUT_WIDTH-1:0]`. The FSM has two states, IDLE and BUSY.
- BUSY is defined as pend != 0, so no separate state flop is needed. An explicit flop is allowed if it stays consistent with pend.
- Load: a vector is loaded when `in_valid & in_ready`, and pend <= `in`.
  - A zero vector is accepted and discarded: no beats are emitted and the block stays IDLE.
- The internal `ffs_m` is fed from pend.
  - `out_valid` = (pend != 0).
  - `out` = `ffs_m` out when `out_valid`, otherwise all zeros. `out` never shows X.
- `out_last` = `out_valid` and pend has exactly one bit set. It is 0 when `out_valid` = 0.
- Beat: a beat completes when `out_valid & out_ready`. pend[out] is then cleared and all other bits are kept.
- `in_ready` = IDLE | (`out_valid & out_ready & out_last`), so a new vector can load on the same edge that retires the last beat.
  - If that load and the final clear coincide, the load wins and pend <= `in`.
- While BUSY and not on the last beat, `in` and `in_valid` are ignored.
- Index arithmetic follows `ffs_m`: bit i reports index i, with 0 = lsb. For INPUT_WIDTH = 1, `out` is 1 bit and always 0.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, `out` and `out_last` hold constant.

## Timing
- Reset (`rst_n` low, asynchronous):
  - pend = 0
  - `out_valid` = 0, `out` = 0, `out_last` = 0
  - `in_ready` = 1
- Reset mid-iteration: the remaining indices are dropped immediately and no further beats are emitted after release.
- Load-to-first-beat latency: a vector accepted at edge N presents its first index in the cycle after edge N. There is no combinational path from `in` to `out`.
- Throughput with `out_ready` held at 1: one index per cycle. Back-to-back vectors have zero bubble cycles.
- A vector with k set bits takes exactly k accepted beats. `in_ready` is high only in the cycle of the k-th beat, or while IDLE.
- `out_ready` may be asserted without `out_valid`; it has no effect.
- `in_valid` may drop without `in_ready`; no state changes.

## Test plan
- INPUT_WIDTH = 8, SIDE = 0, `in` = 8'b1010_0100 loaded, `out_ready` = 1:
  - `out` = 7, 5, 2 on consecutive cycles, with `out_last` only on 2.
  - `in_ready` = 1 on the third beat, then the block is IDLE.
- Same vector with SIDE = 1:
  - `out` = 2, 5, 7, with `out_last` on 7.
- Backpressure: hold `out_ready` = 0 for 4 cycles after load of 8'b0001_1000:
  - `out` = 4 stable with `out_last` = 0.
  - Release `out_ready`, then `out` = 3 with `out_last` = 1.
- Zero vector and back-to-back:
  - Load 8'h00: no `out_valid`, and `in_ready` stays 1.
  - Load 8'h01 while presenting 8'h80 on the final beat: 8'h80 is accepted on that edge and `out` = 7 follows the next cycle.
- Reset mid-op: load 8'hFF, take 2 beats, then pulse `rst_n` low asynchronously between edges:
  - `out_valid` drops immediately and `in_ready` = 1.
  - No stale indices appear after release.
- INPUT_WIDTH = 5 and INPUT_WIDTH = 1, random vectors against a reference model: the emitted index sets match the set bits exactly, in the SIDE-defined order.
